uart_tx: RTL and testbench

- Serial transmitter that drives the line sampled by the on-chip UART receiver or by an external UART.
- Accepts one byte per valid/ready handshake from a local producer (SPI/I2C bridge logic, debug stream).
- Emits 8N1 frames LSB first: start bit (0), 8 data bits, stop bit (1).
- Each bit is held for exactly BAUD_TICKS clocks, the same timing convention the receiver uses.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_tick.sv | 35 +++
 rtl/uart_tx.sv | 156 +++++++++++++++
 tb/tb_uart_tx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter (and, later, the receiver).
//   - uart_state_t     : transmitter frame states
//   - UART_DATA_BITS   : payload bits per frame
//   - UART_FRAME_BITS  : total bit slots per frame (10, or 11 with UART_TX_PARITY_EN)
//   - UART_IDLE/START  : line levels for idle/stop and start
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity slot).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        GUARD
    } uart_state_t;

    localparam int UART_DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    localparam int UART_FRAME_BITS = 11;
`else
    localparam int UART_FRAME_BITS = 10;
`endif

    localparam logic UART_IDLE  = 1'b1;
    localparam logic UART_START = 1'b0;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: 32-bit bit-period counter with synchronous clear.
// Ports:
//   i_clk      system clock
//   i_rst      asynchronous active-high reset
//   i_clr      restart the count from 0 on the next edge
//   o_count    current count value
//   o_bit_end  high while count == BAUD_TICKS-1 (last clock of a bit)
module uart_baud_tick #(
    parameter logic [31:0] BAUD_TICKS = 32'd434
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    output logic [31:0] o_count,
    output logic        o_bit_end
);

    localparam logic [31:0] LAST_TICK = BAUD_TICKS - 32'd1;

    logic [31:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 32'd1;
        end
    end

    assign o_count   = r_count;
    assign o_bit_end = (r_count == LAST_TICK);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter, LSB first, BAUD_TICKS clocks per bit,
// optional IDLE_GUARD clocks of line-high after the stop bit.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity slot
// between the data bits and the stop bit (11-bit frames).
// Ports:
//   clk       system clock
//   reset     asynchronous active-high reset
//   in_data   byte to transmit, latched on the accept edge
//   in_valid  producer has a byte
//   in_ready  block accepts a byte this cycle (IDLE and not in reset)
//   tx        registered serial line, idle high
//   busy      frame or guard in progress
//   done      one-cycle pulse on entering IDLE after stop/guard
module uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BAUD_TICKS = 32'd434,
    parameter logic [15:0] IDLE_GUARD = 16'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0]  LAST_BIT   = 3'(UART_DATA_BITS - 1);
    // Only meaningful when IDLE_GUARD > 0; GUARD is never entered otherwise.
    localparam logic [15:0] GUARD_LAST = IDLE_GUARD - 16'd1;

    uart_state_t r_state;
    logic        r_tx;
    logic        r_done;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_idx;
`ifdef UART_TX_PARITY_EN
    logic        r_parity;
`endif

    logic [31:0] w_count;
    logic        w_bit_end;
    logic        w_guard_end;
    logic        w_slot_end;
    logic        w_clr;
    logic        w_accept;

    // The tick counter is held at 0 in IDLE and restarts at every slot
    // boundary, so each state/bit begins counting from 0.
    assign w_guard_end = (w_count == {16'd0, GUARD_LAST});
    assign w_slot_end  = (r_state == GUARD) ? w_guard_end : w_bit_end;
    assign w_clr       = (r_state == IDLE) || w_slot_end;

    uart_baud_tick #(
        .BAUD_TICKS (BAUD_TICKS)
    ) u_baud_tick (
        .i_clk     (clk),
        .i_rst     (reset),
        .i_clr     (w_clr),
        .o_count   (w_count),
        .o_bit_end (w_bit_end)
    );

    assign in_ready = (r_state == IDLE) && !reset;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_tx      <= UART_IDLE;
            r_done    <= 1'b0;
            r_shift   <= '0;
            r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift   <= in_data;
                        r_bit_idx <= '0;
                        r_tx      <= UART_START;
                        r_state   <= START;
`ifdef UART_TX_PARITY_EN
                        r_parity  <= ^in_data;
`endif
                    end
                end
                START: begin
                    if (w_slot_end) begin
                        r_tx      <= r_shift[0];
                        r_bit_idx <= '0;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_slot_end) begin
                        if (r_bit_idx == LAST_BIT) begin
                            r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            r_tx      <= r_parity;
                            r_state   <= PARITY;
`else
                            r_tx      <= UART_IDLE;
                            r_state   <= STOP;
`endif
                        end else begin
                            // tx is registered, so the next bit is taken
                            // from position 1 of the pre-shift value.
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_slot_end) begin
                        r_tx    <= UART_IDLE;
                        r_state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (w_slot_end) begin
                        if (IDLE_GUARD != 16'd0) begin
                            r_state <= GUARD;
                        end else begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                GUARD: begin
                    if (w_slot_end) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_tx    <= UART_IDLE;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx   = r_tx;
    assign busy = (r_state != IDLE);
    assign done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized stimulus against a frame-level timing model of uart_tx,
// plus directed literal checks (0xA5 waveform, done timing, async reset).
module tb_uart_tx;
    import uart_pkg::*;

    localparam int BT    = 4;
    localparam int GD    = 3;
    localparam int FRAME = UART_FRAME_BITS * BT;
    localparam int LAST  = FRAME + GD;

`ifdef UART_TX_PARITY_EN
    localparam int         NSLOT    = 11;
    localparam int         LIT_DONE = 47;
    localparam logic [10:0] LIT_A5  = 11'b10101001010;
`else
    localparam int         NSLOT    = 10;
    localparam int         LIT_DONE = 43;
    localparam logic [10:0] LIT_A5  = 11'b01101001010;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    uart_tx #(
        .BAUD_TICKS (32'(BT)),
        .IDLE_GUARD (16'(GD))
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%b want=%b", nm, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    // A frame accepted at the end of cycle e occupies cycles s=e+1 .. s+LAST-1;
    // done is high in cycle s+LAST, which is also the first acceptable cycle.
    int         cyc    = 0;
    bit         m_has  = 1'b0;
    int         m_s    = 0;
    logic [7:0] m_byte = '0;

    function automatic logic m_bit(input int slot, input logic [7:0] b);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if (UART_FRAME_BITS == 11 && slot == 9) return ^b;
        return 1'b1;
    endfunction

    function automatic bit m_ready_at(input int c);
        return !(m_has && (c - m_s) < LAST);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_has = 1'b0;
        end else if (in_valid && m_ready_at(cyc)) begin
            m_has  = 1'b1;
            m_s    = cyc + 1;
            m_byte = in_data;
        end
        cyc = cyc + 1;
    end

    int   k;
    logic e_busy, e_tx, e_done;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            chk("rst_tx", tx, 1'b1);
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
            chk("rst_ready", in_ready, 1'b0);
        end else begin
            k      = cyc - m_s;
            e_busy = m_has && (k < LAST);
            e_tx   = (e_busy && k < FRAME) ? m_bit(k / BT, m_byte) : 1'b1;
            e_done = m_has && (k == LAST);
            chk("tx", tx, e_tx);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("in_ready", in_ready, !e_busy);
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!m_ready_at(cyc) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            total++;
            bad++;
            $display("FAIL wait_ready timeout n=%0d", n);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [10:0] lit;
    logic [10:0] slots;
    int          n;
    int          low;
    bit          got_done;

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        lit      = LIT_A5;
        slots    = '0;
        repeat (3) @(negedge clk);
        chk("hold_rst_ready", in_ready, 1'b0);
        chk("hold_rst_tx", tx, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1'b1);

        // Directed 0xA5: literal slot values, done timing, in_ready low time.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        n        = 0;
        low      = 0;
        got_done = 1'b0;
        while (n < 200 && !got_done) begin
            if ((n % BT) == 0 && (n / BT) < NSLOT) slots[n / BT] = tx;
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (!in_ready) low++;
                @(negedge clk);
                n++;
            end
        end
        chk("a5_done_seen", got_done, 1'b1);
        chk_int("a5_done_at", n, LIT_DONE);
        chk_int("a5_ready_low", low, LIT_DONE);
        for (int j = 0; j < NSLOT; j++) chk("a5_slot", slots[j], lit[j]);

        // Back-to-back with in_data toggling every cycle.
        in_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            in_data = 8'($urandom);
            @(negedge clk);
        end

        // Sparse random traffic.
        for (int i = 0; i < 1500; i++) begin
            in_valid = ($urandom_range(0, 3) == 0);
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;

        // Reset in the middle of data bit 3 of 0xF0.
        wait_ready();
        in_valid = 1'b1;
        in_data  = 8'hF0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4 * BT + 1) @(negedge clk);
        chk("f0_bit3_low", tx, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("arst_tx", tx, 1'b1);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_ready", in_ready, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h12;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (LAST + 5) @(negedge clk);

        // Random tail with in_valid mostly high.
        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (LAST + 5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
